// File: rtl/spi_prog_pkg.sv
// Shared opcodes, frame geometry and FSM state encoding for the SPI programming master.
package spi_prog_pkg;

  localparam logic [7:0] OP_DATECODE = 8'h01;
  localparam logic [7:0] OP_STATUS   = 8'h02;
  localparam logic [7:0] OP_WR_CTRL  = 8'h03;
  localparam logic [7:0] OP_WR_ADDR  = 8'h04;
  localparam logic [7:0] OP_RD_ADDR  = 8'h05;
  localparam logic [7:0] OP_WR_DATA  = 8'h06;
  localparam logic [7:0] OP_LD_DATA  = 8'h07;
  localparam logic [7:0] OP_RD_DATA  = 8'h08;

  localparam int FRAME_BITS = 40;
  localparam int RSP_BITS   = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_prog_master_if.sv
// Command/response handshake between the host sequencer (master) and the SPI engine (slave).
interface spi_prog_master_if;
  import spi_prog_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [7:0]            cmd_op;
  logic [RSP_BITS-1:0]   cmd_data;
  logic                  rsp_valid;
  logic [RSP_BITS-1:0]   rsp_data;
  logic                  busy;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/spi_prog_sclk_gen.sv
// SCLK generator: half-period counter producing spi_clk plus strobes that mark the edge about to happen.
module spi_prog_sclk_gen #(
  parameter int HALF_PERIOD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic spi_clk,
  output logic rise,
  output logic fall
);

  localparam logic [15:0] HP_LAST = 16'(HALF_PERIOD - 1);

  logic [15:0] hp_cnt_reg;
  logic        sclk_reg;
  logic        half_done;

  assign half_done = en && (hp_cnt_reg == HP_LAST);

  // Disabled means parked at the start of a low half, so every frame begins identically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt_reg <= '0;
      sclk_reg   <= 1'b0;
    end else if (!en) begin
      hp_cnt_reg <= '0;
      sclk_reg   <= 1'b0;
    end else if (half_done) begin
      hp_cnt_reg <= '0;
      sclk_reg   <= ~sclk_reg;
    end else begin
      hp_cnt_reg <= hp_cnt_reg + 16'd1;
    end
  end

  assign rise    = half_done & ~sclk_reg;
  assign fall    = half_done &  sclk_reg;
  assign spi_clk = sclk_reg;

endmodule

// File: rtl/spi_prog_master.sv
// SPI command engine: sends {op,data} MSB-first and returns the 32-bit word clocked in after the opcode.
// Optional build macro SPI_PROG_MASTER_LOOPBACK_EN adds a loopback input feeding rx from the outgoing MOSI.
module spi_prog_master
  import spi_prog_pkg::*;
#(
  parameter int HALF_PERIOD = 8,
  parameter int CS_SETUP    = 4,
  parameter int CS_GAP      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_prog_master_if.slave  cmd_if,
`ifdef SPI_PROG_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              spi_clk,
  output logic              spi_en_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);
  localparam logic [5:0]  LAST_BIT   = 6'(FRAME_BITS);
  localparam logic [5:0]  FIRST_RX   = 6'(FRAME_BITS - RSP_BITS);

  state_t                state_reg, state_next;
  logic [15:0]           cnt_reg, cnt_next;
  logic [5:0]            bit_cnt_reg, bit_cnt_next;
  logic [FRAME_BITS-1:0] shreg_reg, shreg_next;
  logic [RSP_BITS-1:0]   rx_reg, rx_next;
  logic [RSP_BITS-1:0]   rsp_data_reg, rsp_data_next;
  logic                  en_n_reg, en_n_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [1:0]            miso_sync_reg;
  logic                  rx_bit;
  logic                  sclk_rise, sclk_fall;

  spi_prog_sclk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_sclk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_reg == SHIFT),
    .spi_clk (spi_clk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sync_reg <= '0;
    end else begin
      miso_sync_reg <= {miso_sync_reg[0], spi_miso};
    end
  end

`ifdef SPI_PROG_MASTER_LOOPBACK_EN
  assign rx_bit = loopback ? shreg_reg[FRAME_BITS-1] : miso_sync_reg[1];
`else
  assign rx_bit = miso_sync_reg[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      shreg_reg     <= '0;
      rx_reg        <= '0;
      rsp_data_reg  <= '0;
      en_n_reg      <= 1'b1;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shreg_reg     <= shreg_next;
      rx_reg        <= rx_next;
      rsp_data_reg  <= rsp_data_next;
      en_n_reg      <= en_n_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shreg_next     = shreg_reg;
    rx_next        = rx_reg;
    rsp_data_next  = rsp_data_reg;
    en_n_next      = en_n_reg;
    rsp_valid_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (cmd_if.cmd_valid) begin
          state_next   = SETUP;
          cnt_next     = '0;
          bit_cnt_next = '0;
          shreg_next   = {cmd_if.cmd_op, cmd_if.cmd_data};
          rx_next      = '0;
          en_n_next    = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      SHIFT: begin
        // Bits after the opcode carry the slave's reply; sample them as SCLK rises.
        if (sclk_rise) begin
          bit_cnt_next = bit_cnt_reg + 6'd1;
          if (bit_cnt_reg >= FIRST_RX) begin
            rx_next = {rx_reg[RSP_BITS-2:0], rx_bit};
          end
        end
        if (sclk_fall) begin
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = HOLD;
            shreg_next = '0;
          end else begin
            shreg_next = {shreg_reg[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next     = GAP;
          cnt_next       = '0;
          en_n_next      = 1'b1;
          rsp_valid_next = 1'b1;
          rsp_data_next  = rx_reg;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cmd_if.cmd_ready = (state_reg == IDLE);
  assign cmd_if.busy      = (state_reg != IDLE);
  assign cmd_if.rsp_valid = rsp_valid_reg;
  assign cmd_if.rsp_data  = rsp_data_reg;
  assign spi_en_n         = en_n_reg;
  assign spi_mosi         = shreg_reg[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_prog_master.sv
// Directed bench for spi_prog_master with a behavioural CPLD slave sampling the SPI pins on clk.
module tb_spi_prog_master;
  import spi_prog_pkg::*;

  localparam int HALF_PERIOD = 8;
  localparam int CS_SETUP    = 4;
  localparam int CS_GAP      = 16;
  localparam int LATENCY     = 1 + CS_SETUP + 80 * HALF_PERIOD + HALF_PERIOD;

  localparam logic [31:0] DATECODE_WORD = 32'h8002_3456;
  localparam logic [31:0] STATUS_WORD   = 32'h0000_00A5;
  localparam logic [31:0] RDDATA_WORD   = 32'h1234_5678;
  localparam logic [31:0] OTHER_WORD    = 32'h5A5A_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_clk, spi_en_n, spi_mosi, spi_miso;
  int   tie_mode = 0;
`ifdef SPI_PROG_MASTER_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  spi_prog_master_if bus();

  spi_prog_master #(
    .HALF_PERIOD(HALF_PERIOD),
    .CS_SETUP(CS_SETUP),
    .CS_GAP(CS_GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_if(bus),
`ifdef SPI_PROG_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .spi_clk(spi_clk),
    .spi_en_n(spi_en_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] slave_word(input logic [7:0] op);
    case (op)
      OP_DATECODE: return DATECODE_WORD;
      OP_STATUS:   return STATUS_WORD;
      OP_RD_DATA:  return RDDATA_WORD;
      default:     return OTHER_WORD;
    endcase
  endfunction

  // Slave model: mode-0, captures MOSI on SCLK rise, shifts reply out on SCLK fall after the opcode.
  logic [5:0]  s_rise = '0;
  logic [39:0] s_mosi = '0;
  logic [31:0] s_resp = '0;
  logic        s_miso = 1'b0;
  logic        prev_en_n = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!spi_en_n && prev_en_n) begin
      s_rise = '0;
      s_mosi = '0;
      s_miso = 1'b0;
    end
    if (!spi_en_n && spi_clk && !prev_sclk) begin
      s_mosi = {s_mosi[38:0], spi_mosi};
      s_rise = s_rise + 6'd1;
      if (s_rise == 6'd8) s_resp = slave_word(s_mosi[7:0]);
    end
    if (!spi_en_n && !spi_clk && prev_sclk && s_rise >= 6'd8 && s_rise < 6'd40) begin
      s_miso = s_resp[31];
      s_resp = {s_resp[30:0], 1'b0};
    end
    prev_en_n = spi_en_n;
    prev_sclk = spi_clk;
  end

  assign spi_miso = (tie_mode == 1) ? 1'b1 : (tie_mode == 2) ? 1'b0 : s_miso;

  // Monitor: accepts, responses, rsp_valid pulse width, chip-select idle time.
  int cyc = 0;
  int n_acc = 0, n_rsp = 0;
  int last_acc_cyc = 0, last_rsp_cyc = 0;
  int rv_run = 0, rv_width = 0;
  int en_hi_run = 0, last_gap = 0;
  logic [31:0] last_rsp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) begin
      n_acc++;
      last_acc_cyc = cyc;
    end
    if (bus.rsp_valid) begin
      if (rv_run == 0) begin
        n_rsp++;
        last_rsp_cyc = cyc;
        last_rsp = bus.rsp_data;
      end
      rv_run++;
    end else if (rv_run != 0) begin
      rv_width = rv_run;
      rv_run = 0;
    end
    if (spi_en_n) en_hi_run++;
    else begin
      if (en_hi_run != 0) last_gap = en_hi_run;
      en_hi_run = 0;
    end
  end

  task automatic wait_acc(input int target);
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk);
      if (n_acc >= target) ok = 1;
    end
    if (!ok) check_eq("acc_timeout", n_acc, target);
  endtask

  task automatic wait_rsp(input int target);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      if (n_rsp >= target) ok = 1;
    end
    if (!ok) check_eq("rsp_timeout", n_rsp, target);
    repeat (3) @(posedge clk);
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] data);
    int a0 = n_acc;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    wait_acc(a0 + 1);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] op, input logic [31:0] data,
                         input logic [31:0] exp_rsp);
    int r0 = n_rsp;
    issue(op, data);
    wait_rsp(r0 + 1);
    $display("cmd %s op=%02h data=%08h rsp=%08h lat=%0d rises=%0d", tag, op, data, last_rsp,
             last_rsp_cyc - last_acc_cyc, s_rise);
    check_eq({tag, "_rsp"}, last_rsp, exp_rsp);
    check_eq({tag, "_lat"}, last_rsp_cyc - last_acc_cyc, LATENCY);
    check_eq({tag, "_rises"}, s_rise, 40);
    check_eq({tag, "_mosi"}, s_mosi, {op, data});
    check_eq({tag, "_rv_width"}, rv_width, 1);
  endtask

  initial begin
    int a0, r0, acc2;
    int rsp1_cyc;
    logic [31:0] rsp1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_en_n", spi_en_n, 1);
    check_eq("rst_sclk", spi_clk, 0);
    check_eq("rst_mosi", spi_mosi, 0);
    check_eq("rst_ready", bus.cmd_ready, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_data", bus.rsp_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic frames, then back-to-back with minimum chip-select gap
    run_cmd("datecode", OP_DATECODE, 32'h0, DATECODE_WORD);
    run_cmd("wr_addr", OP_WR_ADDR, 32'h0000_0C00, OTHER_WORD);
    run_cmd("status", OP_STATUS, 32'h0, STATUS_WORD);
    check_eq("cs_gap_ok", last_gap >= CS_GAP, 1);

    a0 = n_acc;
    r0 = n_rsp;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_STATUS;
    bus.cmd_data  = 32'h0;
    wait_acc(a0 + 1);
    #1;
    bus.cmd_op   = OP_RD_DATA;
    bus.cmd_data = 32'h0000_0040;
    wait_rsp(r0 + 1);
    rsp1     = last_rsp;
    rsp1_cyc = last_rsp_cyc;
    check_eq("b2b_no_accept_busy", n_acc - a0, 1);
    wait_acc(a0 + 2);
    #1 bus.cmd_valid = 1'b0;
    acc2 = last_acc_cyc;
    $display("cmd b2b first rsp=%08h at %0d, second accept at %0d", rsp1, rsp1_cyc, acc2);
    check_eq("b2b_gap_ok", (acc2 - rsp1_cyc) >= CS_GAP, 1);
    wait_rsp(r0 + 2);
    $display("cmd b2b second rsp=%08h", last_rsp);
    check_eq("b2b_rsp1", rsp1, STATUS_WORD);
    check_eq("b2b_rsp2", last_rsp, RDDATA_WORD);
    check_eq("b2b_accepts", n_acc - a0, 2);

    // Reset in the middle of a frame
    r0 = n_rsp;
    issue(OP_DATECODE, 32'h0);
    for (int i = 0; i < 1000 && s_rise != 6'd20; i++) @(posedge clk);
    check_eq("mid_rise20", s_rise, 20);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("cmd reset mid-frame at rise %0d", s_rise);
    check_eq("mid_rst_en_n", spi_en_n, 1);
    check_eq("mid_rst_sclk", spi_clk, 0);
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_rsp_data", bus.rsp_data, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (700) @(posedge clk);
    check_eq("mid_rst_no_rsp", n_rsp - r0, 0);
    run_cmd("post_rst", OP_DATECODE, 32'h0, DATECODE_WORD);

    // MISO stuck high / low
    tie_mode = 1;
    run_cmd("tie1", OP_STATUS, 32'h0, 32'hFFFF_FFFF);
    tie_mode = 2;
    run_cmd("tie0", OP_STATUS, 32'h0, 32'h0000_0000);
    tie_mode = 0;

`ifdef SPI_PROG_MASTER_LOOPBACK_EN
    tie_mode = 2;
    loopback = 1'b1;
    run_cmd("loopback", OP_WR_DATA, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    loopback = 1'b0;
    tie_mode = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
